// File: rtl/csa_mp_sequencer.sv
// Multi-precision add/subtract sequencer. It drives one external WIDTH-bit carry-select
// adder slice per cycle, least-significant slice first, and chains the carry through a register.
module csa_mp_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] op_a,
    input  logic [WIDTH*WORDS-1:0] op_b,
    input  logic                   sub,
    input  logic                   cin,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] result,
    output logic                   carry_out,
    output logic                   overflow
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          carry_q, carry_d;
    logic [WORDS-1:0][WIDTH-1:0]   a_q, a_d;
    logic [WORDS-1:0][WIDTH-1:0]   b_q, b_d;
    logic [WORDS-1:0][WIDTH-1:0]   result_q, result_d;
    logic                          carry_out_q, carry_out_d;
    logic                          overflow_q, overflow_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state and adder-slice drive
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so B is inverted once at capture
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub | cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                add_a            = a_q[idx_q];
                add_b            = b_q[idx_q];
                add_cin          = carry_q;
                result_d[idx_q]  = add_sum;
                carry_d          = add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d     = S_DONE;
                    carry_out_d = add_cout;
                    overflow_d  = (a_q[WORDS-1][WIDTH-1] == b_q[WORDS-1][WIDTH-1]) &&
                                  (add_sum[WIDTH-1] != a_q[WORDS-1][WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_csa_mp_sequencer.sv
// Scoreboard bench for csa_mp_sequencer with a behavioural adder slice attached.
module tb_csa_mp_sequencer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned WORDS = 4;
    localparam int unsigned TOTAL = WIDTH * WORDS;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [TOTAL-1:0] op_a;
    logic [TOTAL-1:0] op_b;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [TOTAL-1:0] result;
    logic             carry_out;
    logic             overflow;

    typedef struct packed {
        logic [TOTAL-1:0] res;
        logic             c;
        logic             v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat;
    logic [WIDTH-1:0] sl_a   [20];
    logic [WIDTH-1:0] sl_b   [20];
    logic [WIDTH-1:0] sl_sum [20];
    logic             sl_cin [20];

    always #5 clk = ~clk;

    // Behavioural stand-in for the external carry-select adder slice
    logic [WIDTH:0] adder_full;
    assign adder_full = (WIDTH+1)'(add_a) + (WIDTH+1)'(add_b) + (WIDTH+1)'(add_cin);
    assign add_sum    = adder_full[WIDTH-1:0];
    assign add_cout   = adder_full[WIDTH];

    csa_mp_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow)
    );

    task automatic check_eq(input string tag, input logic [TOTAL-1:0] act, input logic [TOTAL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                                   input logic s, input logic c);
        logic [TOTAL:0] full;
        exp_t e;
        if (s) begin
            full  = {1'b0, a} - {1'b0, b};
            e.res = full[TOTAL-1:0];
            e.c   = ~full[TOTAL];
            e.v   = (a[TOTAL-1] != b[TOTAL-1]) && (e.res[TOTAL-1] != a[TOTAL-1]);
        end else begin
            full  = {1'b0, a} + {1'b0, b} + (TOTAL+1)'(c);
            e.res = full[TOTAL-1:0];
            e.c   = full[TOTAL];
            e.v   = (a[TOTAL-1] == b[TOTAL-1]) && (e.res[TOTAL-1] != a[TOTAL-1]);
        end
        return e;
    endfunction

    task automatic drive_req(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                             input logic s, input logic c);
        op_a     = a;
        op_b     = b;
        sub      = s;
        cin      = c;
        in_valid = 1'b1;
    endtask

    // Takes the edge at which the pending request is accepted
    task automatic accept_req();
        check_eq("ready_before_accept", TOTAL'(in_ready), TOTAL'(1));
        @(posedge clk);
        exp_q.push_back(model(op_a, op_b, sub, cin));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        lat = 0;
        while (!out_valid && lat < 20) begin
            sl_a[lat]   = add_a;
            sl_b[lat]   = add_b;
            sl_sum[lat] = add_sum;
            sl_cin[lat] = add_cin;
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", TOTAL'(lat), TOTAL'(WORDS));
    endtask

    task automatic finish_op(input int hold);
        exp_t e;
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", TOTAL'(out_valid), TOTAL'(1));
            check_eq("hold_in_ready", TOTAL'(in_ready), TOTAL'(0));
            if (exp_q.size() > 0) check_eq("hold_result", result, exp_q[0].res);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        check_eq("done_add_a_zero", TOTAL'(add_a), TOTAL'(0));
        check_eq("done_add_cin_zero", TOTAL'(add_cin), TOTAL'(0));
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_nonempty", TOTAL'(0), TOTAL'(1));
        end else begin
            e = exp_q.pop_front();
            check_eq("result", result, e.res);
            check_eq("carry_out", TOTAL'(carry_out), TOTAL'(e.c));
            check_eq("overflow", TOTAL'(overflow), TOTAL'(e.v));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_valid", TOTAL'(out_valid), TOTAL'(0));
        check_eq("post_in_ready", TOTAL'(in_ready), TOTAL'(1));
    endtask

    task automatic run_op(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                          input logic s, input logic c);
        drive_req(a, b, s, c);
        accept_req();
        wait_out();
        finish_op(0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", TOTAL'(in_ready), TOTAL'(1));
        check_eq("rst_out_valid", TOTAL'(out_valid), TOTAL'(0));
        check_eq("rst_result", result, '0);
        check_eq("rst_flags", TOTAL'({carry_out, overflow}), TOTAL'(0));
        check_eq("rst_add_bus", TOTAL'({add_a, add_b, add_cin}), TOTAL'(0));
        rst = 1'b0;

        // Carry ripple across all slices
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) check_eq("ripple_cin", TOTAL'(sl_cin[i]), TOTAL'(1));
        check_eq("ripple_a0", TOTAL'(sl_a[0]), TOTAL'(16'hFFFF));

        // Subtract with borrow
        run_op(64'h0, 64'h1, 1'b1, 1'b0);
        check_eq("sub_b0", TOTAL'(sl_b[0]), TOTAL'(16'hFFFE));
        for (int i = 1; i < 4; i++) check_eq("sub_bn", TOTAL'(sl_b[i]), TOTAL'(16'hFFFF));
        check_eq("sub_cin0", TOTAL'(sl_cin[0]), TOTAL'(1));

        // Signed overflow both directions
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);

        // Carry-in and chaining
        run_op(64'h0000_0000_0000_FFFF, 64'h0, 1'b0, 1'b1);
        check_eq("chain_sum0", TOTAL'(sl_sum[0]), TOTAL'(0));
        check_eq("chain_cin1", TOTAL'(sl_cin[1]), TOTAL'(1));

        // Backpressure with a competing request held in DONE
        drive_req(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0);
        accept_req();
        wait_out();
        drive_req(64'h0000_0001_0000_0000, 64'h0000_0000_0000_0002, 1'b1, 1'b1);
        finish_op(3);
        check_eq("bp_second_pending", TOTAL'(exp_q.size()), TOTAL'(0));
        accept_req();
        check_eq("bp_second_running", TOTAL'(in_ready), TOTAL'(0));
        wait_out();
        finish_op(1);

        // Reset while idx==2
        drive_req(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
        accept_req();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        check_eq("mid_rst_in_ready", TOTAL'(in_ready), TOTAL'(1));
        check_eq("mid_rst_out_valid", TOTAL'(out_valid), TOTAL'(0));
        check_eq("mid_rst_result", result, '0);
        check_eq("mid_rst_add_bus", TOTAL'({add_a, add_b, add_cin}), TOTAL'(0));
        run_op(64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b1, 1'b0);

        // Mixed random operations
        for (int i = 0; i < 8; i++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
